coin_credit_fsm: RTL and testbench
==================================

# coin_credit_fsm

Parametrised coin-credit controller for the drink vending datapath. It accumulates inserted coins of up to three configurable denominations into a credit register and rejects coins that would exceed a credit ceiling. On a drink selection it compares credit against the selected price, enables the drink-preparation modules, waits for their completion, then returns change. It sits between the coin acceptor front end and the drink preparation modules, driven by a price supplied from the price table.

## Interface
- CREDIT_W, 12, width of credit, price and change values (unsigned)
- MAX_CREDIT, 2000, highest credit the block holds; must be < 2**CREDIT_W
- COIN0_VAL, 100, value added for coin code 2'b01 (0 = denomination disabled)
- COIN1_VAL, 500, value added for coin code 2'b10 (0 = disabled)
- COIN2_VAL, 1000, value added for coin code 2'b11 (0 = disabled)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- moneda  in  2  coin code, 2'b00 = none; one cycle per physical coin (pulsed upstream)
- sel  in  3  drink selection, 3'b000 = none; sampled every cycle
- price  in  CREDIT_W  price of the drink on sel, valid whenever sel != 0
- cancel  in  1  refund request
- done  in  1  drink preparation finished, single-cycle pulse
- credit  out  CREDIT_W  current accumulated credit
- drink  out  3  latched accepted selection, 0 when none
- enable  out  1  drink preparation enable, level
- reject  out  1  one-cycle pulse: the coin presented this cycle was not accepted
- insufficient  out  1  one-cycle pulse: the selection was refused for lack of credit
- change  out  CREDIT_W  change amount, meaningful while change_valid
- change_valid  out  1  one-cycle pulse: return the value on change

## Operation
- States: IDLE (credit 0), COLLECT (credit > 0), DISPENSE, CHANGE.
- Coin value: val(moneda) from COINx_VAL. A coin is accepted in IDLE/COLLECT only if val != 0 and credit + val <= MAX_CREDIT. The sum is computed at CREDIT_W+1 bits, so there is no wrap. Accepted coin: credit += val, state becomes COLLECT. Otherwise reject pulses and credit is unchanged.
- Selection in IDLE/COLLECT, sel != 0:
  - credit >= price: drink <= sel, credit <= credit - price, state DISPENSE.
  - Otherwise insufficient pulses, state and credit unchanged.
- Price 0 is legal and is accepted even from IDLE.
- Priority in IDLE/COLLECT within one cycle: cancel > sel > coin.
  - Cancel in COLLECT goes to CHANGE. Cancel in IDLE is ignored.
  - A coin in the same cycle as an accepted sel or an acted-on cancel is rejected.
  - A coin in the same cycle as a refused sel is evaluated normally.
- DISPENSE:
  - enable = 1.
  - Every non-zero moneda is rejected. sel and cancel are ignored.
  - On done: go to CHANGE if credit > 0, else go to IDLE with drink <= 0.
- CHANGE:
  - change <= credit, change_valid = 1 for exactly one cycle.
  - credit <= 0, drink <= 0, then go to IDLE.
  - Inputs in CHANGE are ignored and coins are rejected.
- credit never exceeds MAX_CREDIT. The comparison credit >= price is unsigned.

## Timing
- All outputs are registered. Reset values: state IDLE, credit 0, drink 0, enable 0, reject 0, insufficient 0, change 0, change_valid 0.
- Coin at cycle N: credit and reject are visible from cycle N+1.
- Accepted sel at N: enable = 1, drink and reduced credit are visible from N+1.
- done at N in DISPENSE: enable = 0 from N+1. change_valid is high in cycle N+1 only, with change equal to the remaining credit; credit is 0 from N+2.
- Refused sel at N: insufficient is high in N+1 only. sel held high re-evaluates each cycle, so it pulses every cycle until enough credit is present.
- done outside DISPENSE is ignored.
- rst asserted at any time, including mid-DISPENSE or CHANGE, forces the reset values immediately. Any credit held is lost; a refund is not issued.

## Test plan
- Reset, then coins 01, 10, 01 -> credit reads 100, 600, 700 on successive cycles; reject stays 0.
- credit 700, sel=3, price=650 -> next cycle enable=1, drink=3, credit=50. done -> change_valid pulse with change=50. Next cycle credit=0, state IDLE.
- credit 1500, coin 11 (1000) -> reject pulse, credit stays 1500. Coin 10 -> credit 2000. Coin 01 -> reject.
- credit 100, sel=2, price=300 -> insufficient pulse, credit 100. Same-cycle coin 10 -> credit 600. Next sel accepted -> credit 300.
- credit 600, cancel with coin 01 in the same cycle -> reject pulse, then change_valid with change=600, credit 0.
- In DISPENSE, coin 10 -> reject, credit unchanged. rst mid-DISPENSE -> enable=0, credit=0, drink=0 immediately. COIN2_VAL=0 build: coin 11 -> reject.

Source files
------------

// File: rtl/coin_credit_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : coin_credit_fsm
//  Description : Coin-credit controller for the drink vending datapath.
//                Accumulates up to three coin denominations into a credit
//                register (bounded by MAX_CREDIT), accepts or refuses drink
//                selections against the supplied price, holds the drink
//                preparation enable until done, then returns change.
//  Revision    : 1.0 - initial release
// ============================================================================
module coin_credit_fsm #(
    parameter int CREDIT_W   = 12,
    parameter int MAX_CREDIT = 2000,
    parameter int COIN0_VAL  = 100,
    parameter int COIN1_VAL  = 500,
    parameter int COIN2_VAL  = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          moneda,
    input  logic [2:0]          sel,
    input  logic [CREDIT_W-1:0] price,
    input  logic                cancel,
    input  logic                done,
    output logic [CREDIT_W-1:0] credit,
    output logic [2:0]          drink,
    output logic                enable,
    output logic                reject,
    output logic                insufficient,
    output logic [CREDIT_W-1:0] change,
    output logic                change_valid
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_COLLECT  = 2'd1;
    localparam logic [1:0] S_DISPENSE = 2'd2;
    localparam logic [1:0] S_CHANGE   = 2'd3;

    localparam logic [CREDIT_W:0]   c_max_credit = MAX_CREDIT[CREDIT_W:0];
    localparam logic [CREDIT_W-1:0] c_coin0_val  = COIN0_VAL[CREDIT_W-1:0];
    localparam logic [CREDIT_W-1:0] c_coin1_val  = COIN1_VAL[CREDIT_W-1:0];
    localparam logic [CREDIT_W-1:0] c_coin2_val  = COIN2_VAL[CREDIT_W-1:0];

    logic [1:0]          r_state;
    logic [CREDIT_W-1:0] r_credit;
    logic [2:0]          r_drink;
    logic                r_enable;
    logic                r_reject;
    logic                r_insufficient;
    logic [CREDIT_W-1:0] r_change;
    logic                r_change_valid;

    logic [CREDIT_W-1:0] w_coin_val;
    logic [CREDIT_W:0]   w_coin_sum;
    logic                w_coin_present;
    logic                w_coin_ok;
    logic                w_sel_ok;
    logic                w_cancel_act;

    // Coin valuation and acceptance test; the sum carries one extra bit so
    // a large coin on a large credit cannot wrap past the ceiling check.
    always_comb begin
        w_coin_val = '0;
        case (moneda)
            2'b01:   w_coin_val = c_coin0_val;
            2'b10:   w_coin_val = c_coin1_val;
            2'b11:   w_coin_val = c_coin2_val;
            default: w_coin_val = '0;
        endcase
        w_coin_present = (moneda != 2'b00);
        w_coin_sum     = {1'b0, r_credit} + {1'b0, w_coin_val};
        w_coin_ok      = (w_coin_val != '0) && (w_coin_sum <= c_max_credit);
        w_sel_ok       = (sel != 3'b000) && (r_credit >= price);
        // Cancel only means something once there is credit to refund.
        w_cancel_act   = cancel && (r_state == S_COLLECT);
    end

    // Main controller: state, credit, selection latch and one-cycle pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_credit       <= '0;
            r_drink        <= 3'b000;
            r_enable       <= 1'b0;
            r_reject       <= 1'b0;
            r_insufficient <= 1'b0;
            r_change       <= '0;
            r_change_valid <= 1'b0;
        end else begin
            r_reject       <= 1'b0;
            r_insufficient <= 1'b0;
            r_change_valid <= 1'b0;
            case (r_state)
                S_IDLE, S_COLLECT: begin
                    if (w_cancel_act) begin
                        // Refund everything; a coin arriving now is bounced.
                        r_state        <= S_CHANGE;
                        r_change       <= r_credit;
                        r_change_valid <= 1'b1;
                        r_reject       <= w_coin_present;
                    end else if (w_sel_ok) begin
                        r_state  <= S_DISPENSE;
                        r_drink  <= sel;
                        r_credit <= r_credit - price;
                        r_enable <= 1'b1;
                        r_reject <= w_coin_present;
                    end else begin
                        // A refused selection still lets a coin land.
                        r_insufficient <= (sel != 3'b000);
                        if (w_coin_present) begin
                            if (w_coin_ok) begin
                                r_credit <= w_coin_sum[CREDIT_W-1:0];
                                r_state  <= S_COLLECT;
                            end else begin
                                r_reject <= 1'b1;
                            end
                        end
                    end
                end
                S_DISPENSE: begin
                    r_reject <= w_coin_present;
                    if (done) begin
                        r_enable <= 1'b0;
                        if (r_credit != '0) begin
                            r_state        <= S_CHANGE;
                            r_change       <= r_credit;
                            r_change_valid <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                            r_drink <= 3'b000;
                        end
                    end
                end
                S_CHANGE: begin
                    // Change was presented on entry; clear and go home.
                    r_reject <= w_coin_present;
                    r_credit <= '0;
                    r_drink  <= 3'b000;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign credit       = r_credit;
    assign drink        = r_drink;
    assign enable       = r_enable;
    assign reject       = r_reject;
    assign insufficient = r_insufficient;
    assign change       = r_change;
    assign change_valid = r_change_valid;

endmodule
`default_nettype wire

// File: tb/tb_coin_credit_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_coin_credit_fsm
//  Description : Self-checking bench for coin_credit_fsm. Two builds run side
//                by side (default and coin 11 disabled), each tracked by a
//                behavioural model; a vector table and hand sequences add
//                fixed expectations for the documented scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_coin_credit_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  moneda = 2'b00;
    logic [2:0]  sel = 3'b000;
    logic [11:0] price = 12'd0;
    logic        cancel = 1'b0;
    logic        done = 1'b0;

    logic [11:0] credit1, change1, credit2, change2;
    logic [2:0]  drink1, drink2;
    logic        enable1, reject1, insuf1, cv1;
    logic        enable2, reject2, insuf2, cv2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    coin_credit_fsm u_dut (
        .clk(clk), .rst(rst), .moneda(moneda), .sel(sel), .price(price),
        .cancel(cancel), .done(done), .credit(credit1), .drink(drink1),
        .enable(enable1), .reject(reject1), .insufficient(insuf1),
        .change(change1), .change_valid(cv1)
    );

    coin_credit_fsm #(.COIN2_VAL(0)) u_dut_nc2 (
        .clk(clk), .rst(rst), .moneda(moneda), .sel(sel), .price(price),
        .cancel(cancel), .done(done), .credit(credit2), .drink(drink2),
        .enable(enable2), .reject(reject2), .insufficient(insuf2),
        .change(change2), .change_valid(cv2)
    );

    // Observable behaviour: dispensing is "enable high", paying out change
    // is "change_valid high", otherwise the controller is taking money.
    typedef struct {
        int credit; int drink; int enable; int reject;
        int insuf;  int change; int cv;
    } mdl_t;

    mdl_t m1, m2;

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.credit = 0; r.drink = 0; r.enable = 0; r.reject = 0;
        r.insuf = 0;  r.change = 0; r.cv = 0;
        return r;
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, int mo, int se, int pr,
                                      int ca, int dn, int c2val);
        mdl_t n;
        int   vals[4];
        bit   coin;
        vals[0] = 0; vals[1] = 100; vals[2] = 500; vals[3] = c2val;
        coin = (mo != 0);
        n = m;
        n.reject = 0; n.insuf = 0; n.cv = 0;
        if (m.cv != 0) begin
            n.credit = 0; n.drink = 0; n.reject = coin;
        end else if (m.enable != 0) begin
            n.reject = coin;
            if (dn != 0) begin
                n.enable = 0;
                if (m.credit > 0) begin n.cv = 1; n.change = m.credit; end
                else n.drink = 0;
            end
        end else if (ca != 0 && m.credit > 0) begin
            n.cv = 1; n.change = m.credit; n.reject = coin;
        end else if (se != 0 && m.credit >= pr) begin
            n.drink = se; n.credit = m.credit - pr; n.enable = 1; n.reject = coin;
        end else begin
            n.insuf = (se != 0);
            if (coin) begin
                if (vals[mo] != 0 && m.credit + vals[mo] <= 2000)
                    n.credit = m.credit + vals[mo];
                else
                    n.reject = 1;
            end
        end
        return n;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_models();
        chk("m1.credit", int'(credit1), m1.credit);
        chk("m1.drink",  int'(drink1),  m1.drink);
        chk("m1.enable", int'(enable1), m1.enable);
        chk("m1.reject", int'(reject1), m1.reject);
        chk("m1.insuf",  int'(insuf1),  m1.insuf);
        chk("m1.cv",     int'(cv1),     m1.cv);
        if (m1.cv != 0) chk("m1.change", int'(change1), m1.change);
        chk("m2.credit", int'(credit2), m2.credit);
        chk("m2.drink",  int'(drink2),  m2.drink);
        chk("m2.enable", int'(enable2), m2.enable);
        chk("m2.reject", int'(reject2), m2.reject);
        chk("m2.insuf",  int'(insuf2),  m2.insuf);
        chk("m2.cv",     int'(cv2),     m2.cv);
        if (m2.cv != 0) chk("m2.change", int'(change2), m2.change);
    endtask

    // One clock: models consume the inputs seen at the edge, outputs
    // are sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        m1 = mdl_step(m1, int'(moneda), int'(sel), int'(price), int'(cancel), int'(done), 1000);
        m2 = mdl_step(m2, int'(moneda), int'(sel), int'(price), int'(cancel), int'(done), 0);
        #1;
        check_models();
    endtask

    task automatic set_in(input int mo, input int se, input int pr,
                          input int ca, input int dn);
        moneda = 2'(mo); sel = 3'(se); price = 12'(pr);
        cancel = 1'(ca); done = 1'(dn);
    endtask

    // Reset asserted between edges; outputs must clear without a clock.
    task automatic do_reset();
        set_in(0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("rst.credit", int'(credit1), 0);
        chk("rst.enable", int'(enable1), 0);
        chk("rst.drink",  int'(drink1),  0);
        chk("rst.cv",     int'(cv1),     0);
        m1 = mdl_reset();
        m2 = mdl_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        int mo; int se; int pr; int ca; int dn;
        int e_credit; int e_drink; int e_en; int e_rej; int e_ins; int e_cv; int e_chg;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(int mo, int se, int pr, int ca, int dn,
                               int cr, int dr, int en, int rj, int ins, int cv, int chg);
        vec_t r;
        r.mo = mo; r.se = se; r.pr = pr; r.ca = ca; r.dn = dn;
        r.e_credit = cr; r.e_drink = dr; r.e_en = en; r.e_rej = rj;
        r.e_ins = ins; r.e_cv = cv; r.e_chg = chg;
        return r;
    endfunction

    initial begin
        //            mo se  pr  ca dn   credit drk en rj in cv change
        vecs.push_back(v(1, 0,   0, 0, 0,  100, 0, 0, 0, 0, 0,    0));
        vecs.push_back(v(2, 0,   0, 0, 0,  600, 0, 0, 0, 0, 0,    0));
        vecs.push_back(v(1, 0,   0, 0, 0,  700, 0, 0, 0, 0, 0,    0));
        vecs.push_back(v(0, 3, 650, 0, 0,   50, 3, 1, 0, 0, 0,    0));
        vecs.push_back(v(0, 0,   0, 0, 0,   50, 3, 1, 0, 0, 0,    0));
        vecs.push_back(v(2, 0,   0, 0, 0,   50, 3, 1, 1, 0, 0,    0));
        vecs.push_back(v(0, 0,   0, 0, 1,   50, 3, 0, 0, 0, 1,   50));
        vecs.push_back(v(0, 0,   0, 0, 0,    0, 0, 0, 0, 0, 0,   50));
        vecs.push_back(v(2, 0,   0, 0, 0,  500, 0, 0, 0, 0, 0,   50));
        vecs.push_back(v(3, 0,   0, 0, 0, 1500, 0, 0, 0, 0, 0,   50));
        vecs.push_back(v(3, 0,   0, 0, 0, 1500, 0, 0, 1, 0, 0,   50));
        vecs.push_back(v(2, 0,   0, 0, 0, 2000, 0, 0, 0, 0, 0,   50));
        vecs.push_back(v(1, 0,   0, 0, 0, 2000, 0, 0, 1, 0, 0,   50));
        vecs.push_back(v(1, 0,   0, 1, 0, 2000, 0, 0, 1, 0, 1, 2000));
        vecs.push_back(v(0, 0,   0, 0, 0,    0, 0, 0, 0, 0, 0, 2000));
        vecs.push_back(v(1, 0,   0, 0, 0,  100, 0, 0, 0, 0, 0, 2000));
        vecs.push_back(v(2, 2, 300, 0, 0,  600, 0, 0, 0, 1, 0, 2000));
        vecs.push_back(v(0, 2, 300, 0, 0,  300, 2, 1, 0, 0, 0, 2000));
        vecs.push_back(v(0, 0,   0, 0, 1,  300, 2, 0, 0, 0, 1,  300));
        vecs.push_back(v(0, 0,   0, 0, 0,    0, 0, 0, 0, 0, 0,  300));
        vecs.push_back(v(2, 0,   0, 0, 0,  500, 0, 0, 0, 0, 0,  300));
        vecs.push_back(v(1, 0,   0, 0, 0,  600, 0, 0, 0, 0, 0,  300));
        vecs.push_back(v(1, 0,   0, 1, 0,  600, 0, 0, 1, 0, 1,  600));
        vecs.push_back(v(0, 0,   0, 0, 0,    0, 0, 0, 0, 0, 0,  600));
        vecs.push_back(v(0, 1,   0, 0, 0,    0, 1, 1, 0, 0, 0,  600));
        vecs.push_back(v(0, 0,   0, 0, 1,    0, 0, 0, 0, 0, 0,  600));
        vecs.push_back(v(1, 0,   0, 1, 0,  100, 0, 0, 0, 0, 0,  600));
        vecs.push_back(v(0, 4, 200, 0, 0,  100, 0, 0, 0, 1, 0,  600));
        vecs.push_back(v(0, 0,   0, 0, 1,  100, 0, 0, 0, 0, 0,  600));

        m1 = mdl_reset();
        m2 = mdl_reset();
        set_in(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset.credit", int'(credit1), 0);
        chk("reset.drink",  int'(drink1),  0);
        chk("reset.enable", int'(enable1), 0);
        chk("reset.reject", int'(reject1), 0);
        chk("reset.insuf",  int'(insuf1),  0);
        chk("reset.change", int'(change1), 0);
        chk("reset.cv",     int'(cv1),     0);
        @(negedge clk);
        rst = 1'b0;

        // Directed table.
        foreach (vecs[i]) begin
            set_in(vecs[i].mo, vecs[i].se, vecs[i].pr, vecs[i].ca, vecs[i].dn);
            tick();
            chk($sformatf("vec%0d.credit", i), int'(credit1), vecs[i].e_credit);
            chk($sformatf("vec%0d.drink",  i), int'(drink1),  vecs[i].e_drink);
            chk($sformatf("vec%0d.enable", i), int'(enable1), vecs[i].e_en);
            chk($sformatf("vec%0d.reject", i), int'(reject1), vecs[i].e_rej);
            chk($sformatf("vec%0d.insuf",  i), int'(insuf1),  vecs[i].e_ins);
            chk($sformatf("vec%0d.cv",     i), int'(cv1),     vecs[i].e_cv);
            chk($sformatf("vec%0d.change", i), int'(change1), vecs[i].e_chg);
        end

        // Build without the third denomination: coin 11 bounces.
        do_reset();
        set_in(3, 0, 0, 0, 0);
        tick();
        chk("nc2.reject", int'(reject2), 1);
        chk("nc2.credit", int'(credit2), 0);
        chk("c2.credit",  int'(credit1), 1000);

        // Held refused selection pulses every cycle until credit arrives.
        do_reset();
        set_in(1, 0, 0, 0, 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            set_in(0, 5, 500, 0, 0);
            tick();
            chk($sformatf("hold%0d.insuf", k), int'(insuf1), 1);
            chk($sformatf("hold%0d.credit", k), int'(credit1), 100);
        end
        set_in(2, 5, 500, 0, 0);
        tick();
        chk("hold.coin.insuf",  int'(insuf1),  1);
        chk("hold.coin.credit", int'(credit1), 600);
        set_in(0, 5, 500, 0, 0);
        tick();
        chk("hold.acc.enable", int'(enable1), 1);
        chk("hold.acc.drink",  int'(drink1),  5);
        chk("hold.acc.credit", int'(credit1), 100);
        chk("hold.acc.insuf",  int'(insuf1),  0);

        // Reset in the middle of dispensing drops everything at once.
        do_reset();
        set_in(0, 0, 0, 0, 0);
        tick();
        chk("post_rst.credit", int'(credit1), 0);

        // Reset while change is being presented.
        set_in(2, 0, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 1, 0);
        tick();
        chk("chg.cv", int'(cv1), 1);
        do_reset();
        set_in(0, 0, 0, 0, 0);
        tick();
        chk("post_rst2.cv", int'(cv1), 0);

        // Randomized traffic against the models.
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            set_in(($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3)),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0,
                   ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 2100)),
                   ($urandom_range(0, 15) == 0) ? 1 : 0,
                   ($urandom_range(0, 3) == 0) ? 1 : 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
